// File: rtl/alu_nibble_seq_if.sv
// alu_nibble_seq_if: command, result and 74181 slice bus of the nibble-serial ALU sequencer
// Ports: start/op_s/op_m/op_ci/opa/opb command in; busy/done/result/cout/zero status out;
// sl_s/sl_m/sl_ci/sl_a/sl_b to the slice, sl_y/sl_co back from it.
// Macro ALU_SEQ_AEQB_EN adds sl_aeqb (slice A=B) and the aeqb flag.
// slave: the sequencer; master: the requester together with the slice.
interface alu_nibble_seq_if #(parameter int WIDTH = 16);
  logic start;
  logic [3:0] op_s;
  logic op_m;
  logic op_ci;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [3:0] sl_s;
  logic sl_m;
  logic sl_ci;
  logic [3:0] sl_a;
  logic [3:0] sl_b;
  logic [3:0] sl_y;
  logic sl_co;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic cout;
  logic zero;
`ifdef ALU_SEQ_AEQB_EN
  logic sl_aeqb;
  logic aeqb;
`endif
  modport slave (
`ifdef ALU_SEQ_AEQB_EN
    input sl_aeqb, output aeqb,
`endif
    input start, op_s, op_m, op_ci, opa, opb, sl_y, sl_co,
    output sl_s, sl_m, sl_ci, sl_a, sl_b, busy, done, result, cout, zero
  );
  modport master (
`ifdef ALU_SEQ_AEQB_EN
    output sl_aeqb, input aeqb,
`endif
    output start, op_s, op_m, op_ci, opa, opb, sl_y, sl_co,
    input sl_s, sl_m, sl_ci, sl_a, sl_b, busy, done, result, cout, zero
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs WIDTH-bit ALU ops through one external 74181 slice, one nibble per clock, LSB first
// Ports: clk, reset (async, active-high), bus (alu_nibble_seq_if.slave, same WIDTH).
// Macro ALU_SEQ_AEQB_EN adds the A=B accumulator driving bus.aeqb.
module alu_nibble_seq #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic reset,
  alu_nibble_seq_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [3:0] s_r;
  logic m_r;
  logic carry;
  logic [WIDTH-1:0] a_r, b_r, result_r, res_nx;
  logic cout_r, zero_r;
  logic last, run, accept;
  assign run = state == RUN;
  assign accept = state == IDLE && bus.start;
  assign last = idx == IW'(NIB - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    bus.busy = run;
    bus.done = state == DONE;
    bus.sl_s = run ? s_r : 4'd0;
    bus.sl_m = run & m_r;
    bus.sl_ci = run & carry;
    bus.sl_a = run ? a_r[4*idx +: 4] : 4'd0;
    bus.sl_b = run ? b_r[4*idx +: 4] : 4'd0;
  end
  // zero must see the nibble being captured at the final edge
  always_comb begin
    res_nx = result_r;
    res_nx[4*idx +: 4] = bus.sl_y;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx <= '0;
      s_r <= '0;
      m_r <= 1'b0;
      carry <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      result_r <= '0;
      cout_r <= 1'b0;
      zero_r <= 1'b0;
    end else if (accept) begin
      idx <= '0;
      s_r <= bus.op_s;
      m_r <= bus.op_m;
      carry <= bus.op_ci;
      a_r <= bus.opa;
      b_r <= bus.opb;
    end else if (run) begin
      result_r <= res_nx;
      carry <= bus.sl_co;
      idx <= idx + IW'(1);
      if (last) begin
        cout_r <= bus.sl_co;
        zero_r <= ~|res_nx;
      end
    end
  assign bus.result = result_r;
  assign bus.cout = cout_r;
  assign bus.zero = zero_r;
`ifdef ALU_SEQ_AEQB_EN
  logic acc, aeqb_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= 1'b0;
      aeqb_r <= 1'b0;
    end else if (accept) acc <= 1'b1;
    else if (run) begin
      acc <= acc & bus.sl_aeqb;
      if (last) aeqb_r <= acc & bus.sl_aeqb;
    end
  assign bus.aeqb = aeqb_r;
`endif
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: scoreboard bench for alu_nibble_seq with a behavioural 74181 slice
module tb_alu_nibble_seq;
  localparam int W = 16;
  localparam int NIB = W / 4;
  typedef struct {
    logic [W-1:0] res;
    logic co;
    logic chk_co;
    logic z;
    logic ae;
    logic chk_ae;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [3:0] t1, t2;
  logic [4:0] sum;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_nibble_seq_if #(.WIDTH(W)) bus ();
  alu_nibble_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  // active-high 74181: arithmetic F = T1 plus T2 plus ~Cn, logic F = ~(T1 ^ T2), Cn+4 low on carry
  always_comb begin
    t1 = bus.sl_a | (bus.sl_b & {4{bus.sl_s[0]}}) | (~bus.sl_b & {4{bus.sl_s[1]}});
    t2 = (bus.sl_a & bus.sl_b & {4{bus.sl_s[3]}}) | (bus.sl_a & ~bus.sl_b & {4{bus.sl_s[2]}});
    sum = {1'b0, t1} + {1'b0, t2} + {4'd0, ~bus.sl_ci};
    bus.sl_y = bus.sl_m ? ~(t1 ^ t2) : sum[3:0];
    bus.sl_co = ~sum[4];
  end
`ifdef ALU_SEQ_AEQB_EN
  assign bus.sl_aeqb = &bus.sl_y;
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset && bus.done) begin
      done_cnt++;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("result", 32'(bus.result), 32'(mon_e.res));
        if (mon_e.chk_co) chk("cout", 32'(bus.cout), 32'(mon_e.co));
        chk("zero", 32'(bus.zero), 32'(mon_e.z));
        chk("done_latency", cyc, mon_e.cyc);
        chk("busy_at_done", 32'(bus.busy), 0);
`ifdef ALU_SEQ_AEQB_EN
        if (mon_e.chk_ae) chk("aeqb", 32'(bus.aeqb), 32'(mon_e.ae));
`endif
      end
    end
  task automatic run_op(input logic [3:0] s, input logic m, input logic ci, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit push, input logic [W-1:0] res, input logic co,
                        input logic chk_co, input logic z, input logic ae, input logic chk_ae);
    exp_t e;
    @(negedge clk);
    bus.op_s = s;
    bus.op_m = m;
    bus.op_ci = ci;
    bus.opa = a;
    bus.opb = b;
    bus.start = 1'b1;
    e = '{res, co, chk_co, z, ae, chk_ae, cyc + 1 + NIB};
    if (push) q.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", q.size(), 0);
    @(negedge clk);
  endtask
  int d0;
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op_s = '0;
    bus.op_m = 1'b0;
    bus.op_ci = 1'b0;
    bus.opa = '0;
    bus.opb = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_flags", {30'd0, bus.cout, bus.zero}, 0);
    chk("rst_slice", {18'd0, bus.sl_s, bus.sl_m, bus.sl_ci, bus.sl_a, bus.sl_b}, 0);
    reset = 1'b0;
    run_op(4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001, 1, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_run", 32'(bus.busy), 1);
    drain();
    chk("hold_result", 32'(bus.result), 32'h0100);
    chk("idle_done_low", 32'(bus.done), 0);
    run_op(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    run_op(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 1, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    run_op(4'b1001, 1'b0, 1'b0, 16'h1234, 16'h4321, 1, 16'h5556, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    run_op(4'b0110, 1'b0, 1'b0, 16'h5000, 16'h1234, 1, 16'h3DCC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    d0 = done_cnt;
    run_op(4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001, 1, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.opa = 16'h1111;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    drain();
    repeat (6) @(negedge clk);
    chk("busy_start_done_count", done_cnt - d0, 1);
    chk("busy_start_result", 32'(bus.result), 32'h0100);
    run_op(4'b1001, 1'b0, 1'b1, 16'hAAAA, 16'h1111, 0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_result", 32'(bus.result), 0);
    chk("midrst_slice", {18'd0, bus.sl_s, bus.sl_m, bus.sl_ci, bus.sl_a, bus.sl_b}, 0);
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    run_op(4'b1001, 1'b0, 1'b1, 16'h0F0F, 16'h00F1, 1, 16'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
`ifdef ALU_SEQ_AEQB_EN
    run_op(4'b0110, 1'b0, 1'b1, 16'hA5A5, 16'hA5A5, 1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();
    run_op(4'b0110, 1'b0, 1'b1, 16'hA5A5, 16'hA5A4, 1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
